electr_config_seq: RTL and testbench

ELECTR_CONFIG_SEQ -- requirements
Module: electr_config_seq

---
 rtl/electr_config_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_electr_config_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/electr_config_seq.sv
// -----------------------------------------------------------------------------
// electr_config_seq
//
// Steps through a small table of electrode configuration words. For each
// pattern it presents the word to a serializer, kicks the serializer with a
// one-cycle enable_desp pulse, waits for sr_finish (guarded by a watchdog),
// applies the shifted word with a one-cycle latch_strobe, then optionally
// idles for gap_cycles before the next pattern. Runs once or loops until abort.
//
// Serializer handshake (enable_desp / sr_finish):
//   enable_desp is a single-cycle request issued with electr_config_out already
//   stable. The serializer answers with sr_finish at any later time. sr_finish
//   is only honoured while the sequencer waits for it (WAIT_SR) and is ignored
//   everywhere else. abort sampled together with sr_finish wins.
//
// Ports
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   start, abort        run request / cancel
//   loop_en             repeat the sequence until abort
//   n_patterns_m1       index of the last pattern of the sequence
//   gap_cycles          idle cycles between patterns
//   wr_en/addr/data     pattern table write port (accepted only while idle)
//   sr_finish           serializer complete
//   electr_config_out   word presented to the serializer
//   enable_desp         serializer start pulse
//   latch_strobe        apply-configuration pulse
//   busy, done          sequence running / one-cycle completion pulse
//   timeout_err         sticky watchdog error, cleared by the next start
//   pat_idx             index of the current pattern
//   dbg_state           current FSM state, for observation only
// -----------------------------------------------------------------------------
module electr_config_seq #(
    parameter int N_ELECTRODES = 55,
    parameter int N_PATTERNS   = 8,   // power of two, at least 2
    parameter int GAP_W        = 8,
    parameter int TIMEOUT      = 63,
    localparam int ADDR_W      = $clog2(N_PATTERNS)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    loop_en,
    input  logic [ADDR_W-1:0]       n_patterns_m1,
    input  logic [GAP_W-1:0]        gap_cycles,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [N_ELECTRODES-1:0] wr_data,
    input  logic                    sr_finish,
    output logic [N_ELECTRODES-1:0] electr_config_out,
    output logic                    enable_desp,
    output logic                    latch_strobe,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [ADDR_W-1:0]       pat_idx,
    output logic [2:0]              dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_KICK    = 3'd2,
        S_WAIT_SR = 3'd3,
        S_LATCH   = 3'd4,
        S_GAP     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_W-1:0]       r_last, w_last_nxt;
    logic [GAP_W-1:0]        r_gap, w_gap_nxt;
    logic                    r_loop, w_loop_nxt;
    logic [ADDR_W-1:0]       r_pat_idx, w_pat_idx_nxt;
    logic [WD_W-1:0]         r_wdog, w_wdog_nxt;
    logic [GAP_W-1:0]        r_gap_cnt, w_gap_cnt_nxt;
    logic [N_ELECTRODES-1:0] r_out, w_out_nxt;
    logic                    r_enable_desp, w_enable_desp_nxt;
    logic                    r_latch, w_latch_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_timeout, w_timeout_nxt;
    logic                    r_busy, w_busy_nxt;
    logic [WD_W-1:0]         w_wdog_inc;
    logic [N_ELECTRODES-1:0] r_table [N_PATTERNS];

    assign w_wdog_inc = r_wdog + WD_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_last_nxt        = r_last;
        w_gap_nxt         = r_gap;
        w_loop_nxt        = r_loop;
        w_pat_idx_nxt     = r_pat_idx;
        w_wdog_nxt        = r_wdog;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_out_nxt         = r_out;
        w_enable_desp_nxt = 1'b0;
        w_latch_nxt       = 1'b0;
        w_done_nxt        = 1'b0;
        w_timeout_nxt     = r_timeout;

        if (r_state == S_IDLE) begin
            if (start && !abort) begin
                w_last_nxt    = n_patterns_m1;
                w_gap_nxt     = gap_cycles;
                w_loop_nxt    = loop_en;
                w_pat_idx_nxt = '0;
                w_timeout_nxt = 1'b0;
                w_state_nxt   = S_LOAD;
            end
        end else if (abort) begin
            // Leaving without any pulse: the pulse defaults above stay 0.
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_LOAD: begin
                    w_out_nxt   = r_table[r_pat_idx];
                    w_state_nxt = S_KICK;
                end
                S_KICK: begin
                    w_enable_desp_nxt = 1'b1;
                    w_wdog_nxt        = '0;
                    w_state_nxt       = S_WAIT_SR;
                end
                S_WAIT_SR: begin
                    if (sr_finish) begin
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_wdog_nxt = w_wdog_inc;
                        if (w_wdog_inc == WD_W'(TIMEOUT)) begin
                            w_timeout_nxt = 1'b1;
                            w_state_nxt   = S_IDLE;
                        end
                    end
                end
                S_LATCH: begin
                    w_latch_nxt = 1'b1;
                    if ((r_pat_idx == r_last) && !r_loop) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pat_idx_nxt = (r_pat_idx == r_last) ? '0 : r_pat_idx + ADDR_W'(1);
                        if (r_gap != '0) begin
                            // Counts down to zero, so the GAP state lasts r_gap cycles.
                            w_gap_cnt_nxt = r_gap - GAP_W'(1);
                            w_state_nxt   = S_GAP;
                        end else begin
                            w_state_nxt = S_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_last        <= '0;
            r_gap         <= '0;
            r_loop        <= 1'b0;
            r_pat_idx     <= '0;
            r_wdog        <= '0;
            r_gap_cnt     <= '0;
            r_out         <= '0;
            r_enable_desp <= 1'b0;
            r_latch       <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last        <= w_last_nxt;
            r_gap         <= w_gap_nxt;
            r_loop        <= w_loop_nxt;
            r_pat_idx     <= w_pat_idx_nxt;
            r_wdog        <= w_wdog_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_out         <= w_out_nxt;
            r_enable_desp <= w_enable_desp_nxt;
            r_latch       <= w_latch_nxt;
            r_done        <= w_done_nxt;
            r_timeout     <= w_timeout_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // The table is only written while idle, so a running sequence always sees
    // a frozen table. A write in the start cycle lands before LOAD reads it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_PATTERNS; i++) begin
                r_table[i] <= '0;
            end
        end else if (wr_en && !r_busy) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    assign electr_config_out = r_out;
    assign enable_desp       = r_enable_desp;
    assign latch_strobe      = r_latch;
    assign busy              = r_busy;
    assign done              = r_done;
    assign timeout_err       = r_timeout;
    assign pat_idx           = r_pat_idx;
    assign dbg_state         = r_state;

endmodule

// File: tb/tb_electr_config_seq.sv
// -----------------------------------------------------------------------------
// tb_electr_config_seq
//
// Each run is described by its parameters (last index, gap, loop, serializer
// delay, abort/reset point). From those the bench predicts the absolute cycle
// of every output pulse with plain timeline arithmetic:
//   first enable_desp  = start sample cycle + 2
//   latch_strobe       = enable_desp + serializer delay + 2
//   next enable_desp   = latch_strobe + gap + 2
//   done               = latch_strobe + 1
//   timeout_err rises  = enable_desp + 63
// Events are queued when the run is issued; a monitor pops and compares each
// pulse the DUT produces. An abort or reset at cycle A drops every event
// predicted after A.
// -----------------------------------------------------------------------------
module tb_electr_config_seq;

    localparam int N  = 55;
    localparam int NP = 8;
    localparam int AW = 3;
    localparam int GW = 8;
    localparam int TO = 63;
    localparam int EW = 2 + 16 + AW + N;

    localparam logic [1:0] K_EN    = 2'd0;
    localparam logic [1:0] K_LATCH = 2'd1;
    localparam logic [1:0] K_DONE  = 2'd2;
    localparam logic [1:0] K_TO    = 2'd3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] n_patterns_m1 = '0;
    logic [GW-1:0] gap_cycles = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_data = '0;
    logic          sr_finish;
    logic [N-1:0]  electr_config_out;
    logic          enable_desp, latch_strobe, busy, done, timeout_err;
    logic [AW-1:0] pat_idx;
    logic [2:0]    dbg_state;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [EW-1:0] exp_q[$];
    logic [N-1:0]  model_tbl [NP];
    bit            ser_on = 1'b0;
    int            ser_delay = 0;
    int            ser_cnt = 0;
    int            spur_at = -1;
    logic          prev_to;

    electr_config_seq dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .start             (start),
        .abort             (abort),
        .loop_en           (loop_en),
        .n_patterns_m1     (n_patterns_m1),
        .gap_cycles        (gap_cycles),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .sr_finish         (sr_finish),
        .electr_config_out (electr_config_out),
        .enable_desp       (enable_desp),
        .latch_strobe      (latch_strobe),
        .busy              (busy),
        .done              (done),
        .timeout_err       (timeout_err),
        .pat_idx           (pat_idx),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ev(input logic [1:0] k, input int c, input int p, input logic [N-1:0] w);
        exp_q.push_back({k, c[15:0], p[AW-1:0], w});
    endtask

    task automatic got(input logic [1:0] k);
        logic [EW-1:0] e;
        logic [1:0]    ek;
        logic [15:0]   ec;
        logic [AW-1:0] ep;
        logic [N-1:0]  ew;
        if (exp_q.size() == 0) begin
            check("unexpected_pulse", 64'(k), 64'hFF);
            return;
        end
        e = exp_q.pop_front();
        {ek, ec, ep, ew} = e;
        check("event_kind", 64'(k), 64'(ek));
        check("event_cycle", 64'(cyc[15:0]), 64'(ec));
        case (ek)
            K_EN: begin
                check("en_word", electr_config_out, ew);
                check("en_pat_idx", pat_idx, ep);
                check("en_busy", busy, 1);
            end
            K_LATCH: begin
                check("latch_pat_idx", pat_idx, ep);
                check("latch_busy", busy, 1);
            end
            default: check("end_busy", busy, 0);
        endcase
    endtask

    // ---------------- monitor ----------------
    initial begin
        prev_to = 1'b0;
        forever begin
            @(negedge CLK);
            if (enable_desp)  got(K_EN);
            if (latch_strobe) got(K_LATCH);
            if (done)         got(K_DONE);
            if (timeout_err && !prev_to) got(K_TO);
            prev_to = timeout_err;
        end
    end

    // ---------------- serializer model ----------------
    initial begin
        sr_finish = 1'b0;
        forever begin
            @(negedge CLK);
            sr_finish = 1'b0;
            if (enable_desp && ser_on) begin
                ser_cnt = ser_delay;
            end else if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) sr_finish = 1'b1;
            end
            if (cyc == spur_at) sr_finish = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [N-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[N-1:0];
    endfunction

    task automatic reset_checks();
        check("rst_out", electr_config_out, 0);
        check("rst_enable_desp", enable_desp, 0);
        check("rst_latch_strobe", latch_strobe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_pat_idx", pat_idx, 0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1 reset_checks();
        foreach (model_tbl[i]) model_tbl[i] = '0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic tbl_write(input int a, input logic [N-1:0] d);
        @(negedge CLK);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        model_tbl[a] = d;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    // kill: 0 none, 1 abort at t+a_off, 2 reset at t+a_off.
    // Offsets < 0 disable the optional actions.
    task automatic run_seq(input int last, input int gap, input bit loop, input int dly,
                           input bit son, input int kill, input int a_off,
                           input int again_off, input int bwr_off, input int spur_off,
                           input bit same_wr);
        int s, t, a, en, lt, idx, nidx, last_c, end_c;
        bit fin;
        logic [N-1:0] nw;
        @(negedge CLK);
        ser_on = son;
        ser_delay = dly;
        ser_cnt = 0;
        start = 1'b1;
        loop_en = loop;
        n_patterns_m1 = AW'(last);
        gap_cycles = GW'(gap);
        if (same_wr) begin
            nw = rand_word();
            wr_en = 1'b1;
            wr_addr = '0;
            wr_data = nw;
            model_tbl[0] = nw;
        end
        s = cyc;
        t = s + 1;
        a = t + a_off;
        spur_at = (spur_off >= 0) ? t + spur_off : -1;

        idx = 0;
        en = t + 2;
        last_c = t;
        for (int n = 0; n < 4096; n++) begin
            if (kill != 0 && en > a) break;
            push_ev(K_EN, en, idx, model_tbl[idx]);
            last_c = en;
            if (!son) begin
                if (!(kill != 0 && en + TO > a)) push_ev(K_TO, en + TO, idx, '0);
                last_c = en + TO;
                break;
            end
            lt = en + dly + 2;
            if (kill != 0 && lt > a) break;
            fin = (idx == last) && !loop;
            nidx = fin ? idx : ((idx == last) ? 0 : idx + 1);
            push_ev(K_LATCH, lt, nidx, '0);
            last_c = lt;
            if (fin) begin
                if (!(kill != 0 && lt + 1 > a)) push_ev(K_DONE, lt + 1, idx, '0);
                last_c = lt + 1;
                break;
            end
            idx = nidx;
            en = lt + gap + 2;
        end

        end_c = (kill != 0) ? a + 3 : last_c + 3;
        while (cyc < end_c) begin
            @(negedge CLK);
            start = (again_off >= 0 && cyc == t + again_off);
            wr_en = 1'b0;
            abort = 1'b0;
            if (cyc == t + 1) begin
                check("out_at_t1", electr_config_out, model_tbl[0]);
                check("timeout_cleared", timeout_err, 0);
            end
            // Write attempted while running; the model table stays as it is.
            if (bwr_off >= 0 && cyc == t + bwr_off) begin
                wr_en = 1'b1;
                wr_addr = '0;
                wr_data = rand_word();
            end
            if (kill == 1 && cyc == a) abort = 1'b1;
            if (kill == 1 && cyc == a + 1) check("abort_busy", busy, 0);
            if (kill == 2 && cyc == a) begin
                #2 RST_N = 1'b0;
                #1 reset_checks();
                foreach (model_tbl[i]) model_tbl[i] = '0;
            end
            if (kill == 2 && cyc == a + 1) RST_N = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        spur_at = -1;
        check("queue_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int last, gap, dly;
        bit lp;
        #1;
        do_reset();

        // Two-pattern run, serializer answers 55 cycles after each kick.
        tbl_write(0, 55'h3AA55AA3FF);
        tbl_write(1, 55'h1);
        run_seq(1, 0, 0, 55, 1, 0, 0, -1, -1, -1, 0);

        // Serializer silent: watchdog expires, error stays set while idle.
        run_seq(0, 0, 0, 0, 0, 0, 0, -1, -1, -1, 0);
        repeat (3) @(negedge CLK);
        check("timeout_sticky", timeout_err, 1);

        // Looping three patterns with gap 3, a start while busy, then abort.
        tbl_write(2, rand_word());
        run_seq(2, 3, 1, int'($urandom_range(1, 30)), 1, 1, 260, 40, -1, -1, 0);

        // Abort on the very cycle sr_finish arrives.
        run_seq(1, 0, 0, 20, 1, 1, 22, -1, -1, -1, 0);

        // Write while busy plus a stray sr_finish during KICK; next run
        // must still load the old word.
        run_seq(0, 2, 0, 10, 1, 0, 0, -1, 3, 1, 0);
        run_seq(0, 0, 0, 8, 1, 0, 0, -1, -1, -1, 0);

        // Write in the start cycle is picked up by the first LOAD.
        run_seq(1, 1, 0, 6, 1, 0, 0, -1, -1, -1, 1);

        // start together with abort while idle does nothing.
        @(negedge CLK);
        start = 1'b1;
        abort = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        repeat (4) @(negedge CLK);
        check("start_abort_idle", busy, 0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NP; i++) tbl_write(i, rand_word());
            lp   = 1'($urandom_range(0, 1));
            last = int'($urandom_range(0, NP - 1));
            gap  = int'($urandom_range(0, 5));
            dly  = int'($urandom_range(1, 40));
            if (lp) run_seq(last, gap, 1, dly, 1, 1, int'($urandom_range(30, 300)), -1, -1, -1, 0);
            else    run_seq(last, gap, 0, dly, 1, 0, 0, -1, -1, -1, 0);
        end

        // Reset while waiting for the serializer, then the cleared table.
        run_seq(0, 0, 0, 0, 0, 2, 12, -1, -1, -1, 0);
        repeat (5) @(negedge CLK);
        run_seq(1, 0, 0, 5, 1, 0, 0, -1, -1, -1, 0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
